apb_slave_regfile: RTL

APB4 completer (slave) that terminates one PSELx line driven by the APB master of the AXI-to-APB bridge. It holds a bank of NUM_REGS software-visible registers and supports byte-strobed writes. A programmable number of wait states is inserted through PREADY. PSLVERR is raised on decode, alignment, protection and read-only violations. Register contents are exported flat to the peripheral logic, together with a one-cycle write-event pulse.

---
 rtl/apb_slave_regfile.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB4 completer holding a bank of byte-strobed software registers.
// Every transfer gets a fixed number of wait states. Decode, alignment,
// protection and read-only violations return an error response.
// Register contents are exported flat, together with a write-event pulse.
module apb_slave_regfile #(
  parameter int          DATASIZE    = 32,
  parameter int          ADDRSIZE    = 32,
  parameter int          NUM_REGS    = 16,
  parameter int          OFFSET_BITS = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [63:0] RO_MASK     = 64'h0001,
  parameter logic [63:0] SECURE_MASK = 64'h0000
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDRSIZE-1:0]          PADDR,
  input  logic [DATASIZE-1:0]          PWDATA,
  input  logic [DATASIZE/8-1:0]        PSTRB,
  input  logic [2:0]                   PPROT,
  output logic [DATASIZE-1:0]          PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic [DATASIZE-1:0]          status_in,
  output logic [NUM_REGS*DATASIZE-1:0] reg_flat,
  output logic                         write_event,
  output logic [5:0]                   write_index
);

  localparam int IDX_W  = OFFSET_BITS - 2;
  localparam int NBYTES = DATASIZE / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATASIZE-1:0]  prdata_q, prdata_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 wr_q, wr_d;
  logic [DATASIZE-1:0]  regs_q [NUM_REGS];
  logic [DATASIZE-1:0]  regs_d [NUM_REGS];
  logic                 wev_q, wev_d;
  logic [5:0]           widx_q, widx_d;

  // Response is built either from the live setup-cycle bus (zero-wait case)
  // or from the values latched when the transfer was accepted.
  logic [IDX_W-1:0]     setup_idx, resp_idx;
  logic                 resp_wr, resp_err, setup_err;
  logic                 resp_in_range, resp_ro, resp_sec;
  logic [DATASIZE-1:0]  resp_rdata, resp_value;
  logic                 unused_ok;

  // Upper address bits are decoded by the bridge; only PPROT[1] matters here.
  assign unused_ok = ^{PADDR[ADDRSIZE-1:OFFSET_BITS], PPROT[2], PPROT[0]};

  assign setup_idx = PADDR[OFFSET_BITS-1:2];
  assign resp_idx  = (state_q == IDLE) ? setup_idx : idx_q;
  assign resp_wr   = (state_q == IDLE) ? PWRITE : wr_q;

  // Per-register attribute and content lookup for the responding index
  always_comb begin
    resp_in_range = 1'b0;
    resp_ro       = 1'b0;
    resp_sec      = 1'b0;
    resp_rdata    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (resp_idx == IDX_W'(r)) begin
        resp_in_range = 1'b1;
        resp_ro       = RO_MASK[r];
        resp_sec      = SECURE_MASK[r];
        resp_rdata    = regs_q[r];
      end
    end
  end

  // Attribute bits are zero for out-of-range indices, so no extra guard needed.
  assign setup_err  = (PADDR[1:0] != 2'b00) | ~resp_in_range
                    | (resp_sec & PPROT[1]) | (PWRITE & resp_ro);
  assign resp_err   = (state_q == IDLE) ? setup_err : err_q;
  assign resp_value = (resp_err || resp_wr) ? '0
                    : (resp_ro ? status_in : resp_rdata);

  // FSM state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: accept on setup, leave ACCESS on completion or abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (PSEL && !PENABLE) state_d = ACCESS;
      ACCESS:  if (!PSEL || pready_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: wait counting, response loading and write commit
  always_comb begin
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wr_d      = wr_q;
    regs_d    = regs_q;
    wev_d     = 1'b0;
    widx_d    = widx_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d = setup_idx;
          err_d = setup_err;
          wr_d  = PWRITE;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = resp_value;
          end else begin
            cnt_d    = 4'(WAIT_STATES);
            pready_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop everything, commit nothing
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (pready_q) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          if (wr_q && !err_q) begin
            for (int r = 0; r < NUM_REGS; r++) begin
              if (idx_q == IDX_W'(r)) begin
                for (int k = 0; k < NBYTES; k++) begin
                  if (PSTRB[k]) regs_d[r][8*k +: 8] = PWDATA[8*k +: 8];
                end
              end
            end
            wev_d  = 1'b1;
            widx_d = 6'(idx_q);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = resp_value;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and response registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      wev_q     <= 1'b0;
      widx_q    <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      wev_q     <= wev_d;
      widx_q    <= widx_d;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*DATASIZE +: DATASIZE] = regs_q[g];
  end

  assign PREADY      = pready_q;
  assign PSLVERR     = pslverr_q;
  assign PRDATA      = prdata_q;
  assign write_event = wev_q;
  assign write_index = widx_q;

endmodule
